fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Round-robin write-port arbiter that shares the single write port of the asynchronous FIFO among NREQ producers in the write clock domain. It grants one requester at a time for a bounded burst and drives the FIFO's winc/wdata from registers. It throttles on walmost_full/wfull so no word is ever presented to a full FIFO. It sits between the producer blocks and the FIFO write side and runs entirely on wclk.

## Interface
- NREQ, 4, number of requesters (2..8)
- DSIZE, 8, data width; matches FIFO data width
- BURST_MAX, 4, maximum words per grant before forced re-arbitration (1..16)

- wclk  in  1  write-domain clock; all logic on rising edge
- wrst_n  in  1  reset, synchronous and active-low
- req_valid  in  NREQ  requester i has a word on req_data slice i
- req_data  in  NREQ*DSIZE  word for requester i at bits [i*DSIZE +: DSIZE]
- req_ready  out  NREQ  one-hot or zero; a word transfers when req_valid[i] and req_ready[i] are both high at a wclk edge
- wfull  in  1  FIFO full flag (wclk domain)
- walmost_full  in  1  FIFO almost-full flag; FIFO asserts it with at least 1 free slot
- winc  out  1  registered FIFO write strobe
- wdata  out  DSIZE  registered FIFO write data
- grant_id  out  clog2(NREQ)  index of current/last granted requester
- busy  out  1  high when state is GRANT or STALL
- overflow_err  out  1  sticky; set if winc=1 while wfull=1
- word_cnt  out  16  total words written, wraps at 65535 -> 0

## Operation
- States: IDLE, GRANT, STALL. Internal: last_grant (reset NREQ-1), burst_cnt (clog2(BURST_MAX)+1 bits).
- IDLE: req_ready=0. If any req_valid: pick the first valid index searching last_grant+1, last_grant+2, ... modulo NREQ. Load grant_id, clear burst_cnt, go GRANT. No valid: stay.
- GRANT: req_ready[grant_id] = !walmost_full && !wfull; other bits 0.
  - Transfer (valid & ready): winc<=1, wdata<=req_data slice, burst_cnt++, word_cnt++.
  - Transfer with burst_cnt == BURST_MAX-1: last_grant<=grant_id, go IDLE.
  - req_valid[grant_id]=0: last_grant<=grant_id, go IDLE (release, no transfer).
  - walmost_full or wfull high with valid high: go STALL; burst_cnt kept.
- STALL: req_ready=0, grant held regardless of req_valid. When walmost_full=0 and wfull=0: go GRANT.
- winc<=0 in any cycle without a transfer; wdata holds its last value.
- overflow_err set on any edge where winc=1 and wfull=1; cleared only by reset.
- Fairness: a requester with continuous valid waits at most (NREQ-1) grants.

## Timing
- Reset (wrst_n low at edge): state IDLE, winc=0, wdata=0, req_ready=0, grant_id=0, busy=0, overflow_err=0, word_cnt=0, last_grant=NREQ-1, burst_cnt=0. Reset mid-burst drops the registered winc at that edge; untransferred requester words remain with the requester (ready was 0 or transfer not completed).
- Latency: req_valid seen in IDLE at edge N -> GRANT and ready high in cycle N+1 -> winc=1 with that word in cycle N+2.
- Burst: one word per cycle while unthrottled; one IDLE bubble between grants. Peak throughput is BURST_MAX/(BURST_MAX+1).
- Throttle: ready is combinational on walmost_full/wfull in the same cycle. At most one registered word is in flight when walmost_full rises, and that word fits in the guaranteed free slot.
- Simultaneous release and new request: release always passes through IDLE; the new request is arbitrated in that IDLE cycle.

## Test plan
- Single requester 0 streams 10 words (0x10..0x19), BURST_MAX=4 -> winc bursts of 4,4,2 separated by 1-cycle gaps; FIFO holds 0x10..0x19 in order; first winc 2 cycles after valid; word_cnt=10.
- All 4 requesters valid continuously, each word tagged with its id -> grant order 0,1,2,3,0,... with 4 words per grant; no requester starves.
- Fill FIFO (depth 16) with the reader stopped -> req_ready drops the cycle walmost_full rises; exactly 16 words written; wfull=1; overflow_err stays 0; state STALL. Start the reader -> writing resumes after walmost_full clears.
- Requester 2 drops valid after 2 words of a grant -> release to IDLE; next grant goes to 3 if valid, else wraps to 0.
- Reset asserted mid-burst (after 2 words) -> next edge: winc=0, busy=0, grant_id=0, word_cnt=0. After release the first grant goes to requester 0.
- Force wfull=1 with walmost_full=0 while winc is pending -> overflow_err=1 and stays 1 until reset.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ producers.
// Grants one requester for up to BURST_MAX words and throttles on almost-full/full.
module fifo_write_arbiter #(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int BURST_MAX = 4,
  localparam int GW       = $clog2(NREQ),
  localparam int BW       = $clog2(BURST_MAX) + 1
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  input  logic                  walmost_full,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [GW-1:0]         grant_id,
  output logic                  busy,
  output logic                  overflow_err,
  output logic [15:0]           word_cnt
);

  typedef enum logic [1:0] {IDLE, GRANT, STALL} state_e;

  state_e             state_q, state_d;
  logic [GW-1:0]      last_grant_q, last_grant_d;
  logic [GW-1:0]      grant_id_q, grant_id_d;
  logic [BW-1:0]      burst_cnt_q, burst_cnt_d;
  logic               winc_q, winc_d;
  logic [DSIZE-1:0]   wdata_q, wdata_d;
  logic               overflow_err_q, overflow_err_d;
  logic [15:0]        word_cnt_q, word_cnt_d;

  logic               throttled;
  logic [DSIZE-1:0]   cur_data;
  logic               pick_found;
  logic [GW-1:0]      pick_id;

  assign throttled = walmost_full || wfull;

  // Search starts just after the last served requester so nobody starves.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      logic [GW-1:0] cand;
      cand = GW'((int'(last_grant_q) + i) % NREQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  always_comb begin
    cur_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id_q == GW'(i)) cur_data = req_data[i*DSIZE +: DSIZE];
    end
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    grant_id_d     = grant_id_q;
    burst_cnt_d    = burst_cnt_q;
    winc_d         = 1'b0;
    wdata_d        = wdata_q;
    word_cnt_d     = word_cnt_q;
    overflow_err_d = overflow_err_q | (winc_q & wfull);
    req_ready      = '0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d  = pick_id;
          burst_cnt_d = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        // Ready is suppressed during reset so no handshake completes on a reset edge.
        if (wrst_n) req_ready[grant_id_q] = !throttled;
        if (!req_valid[grant_id_q]) begin
          last_grant_d = grant_id_q;
          state_d      = IDLE;
        end else if (throttled) begin
          state_d = STALL;
        end else begin
          winc_d      = 1'b1;
          wdata_d     = cur_data;
          burst_cnt_d = burst_cnt_q + 1'b1;
          word_cnt_d  = word_cnt_q + 16'd1;
          if (burst_cnt_q == BW'(BURST_MAX - 1)) begin
            last_grant_d = grant_id_q;
            state_d      = IDLE;
          end
        end
      end
      STALL: begin
        if (!throttled) state_d = GRANT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state_q        <= IDLE;
      last_grant_q   <= GW'(NREQ - 1);
      grant_id_q     <= '0;
      burst_cnt_q    <= '0;
      winc_q         <= 1'b0;
      wdata_q        <= '0;
      overflow_err_q <= 1'b0;
      word_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      grant_id_q     <= grant_id_d;
      burst_cnt_q    <= burst_cnt_d;
      winc_q         <= winc_d;
      wdata_q        <= wdata_d;
      overflow_err_q <= overflow_err_d;
      word_cnt_q     <= word_cnt_d;
    end
  end

  assign winc         = winc_q;
  assign wdata        = wdata_q;
  assign grant_id     = grant_id_q;
  assign busy         = (state_q != IDLE);
  assign overflow_err = overflow_err_q;
  assign word_cnt     = word_cnt_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: vector table plus throttle, fairness
// and overflow sequences driven against a small FIFO occupancy model.
module tb_fifo_write_arbiter;

  localparam int NREQ      = 4;
  localparam int DSIZE     = 8;
  localparam int BURST_MAX = 4;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        wfull;
  logic        walmost_full;
  logic        winc;
  logic [7:0]  wdata;
  logic [1:0]  grant_id;
  logic        busy;
  logic        overflow_err;
  logic [15:0] word_cnt;

  fifo_write_arbiter #(
    .NREQ(NREQ), .DSIZE(DSIZE), .BURST_MAX(BURST_MAX)
  ) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .wfull(wfull), .walmost_full(walmost_full),
    .winc(winc), .wdata(wdata), .grant_id(grant_id), .busy(busy),
    .overflow_err(overflow_err), .word_cnt(word_cnt)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  ready;
    logic        winc;
    logic [7:0]  wdata;
    logic [1:0]  gid;
    logic        busy;
    logic [15:0] wc;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] written[$];
  logic [7:0] exp_written[$];
  int         checks = 0;
  int         failures = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    wrst_n       = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    walmost_full = 1'b0;
    wfull        = 1'b0;
    tick();
    wrst_n = 1'b1;
  endtask

  task automatic add_vec(input logic r, input logic [3:0] v, input logic [31:0] d,
                         input logic [3:0] rdy, input logic wi, input logic [7:0] wd,
                         input logic [1:0] g, input logic b, input logic [15:0] wc);
    vec_t e;
    e.rst_n = r; e.valid = v; e.data = d; e.ready = rdy; e.winc = wi;
    e.wdata = wd; e.gid = g; e.busy = b; e.wc = wc;
    tbl.push_back(e);
  endtask

  task automatic apply_stimulus();
    foreach (tbl[i]) begin
      wrst_n       = tbl[i].rst_n;
      req_valid    = tbl[i].valid;
      req_data     = tbl[i].data;
      walmost_full = 1'b0;
      wfull        = 1'b0;
      #1;
      check_output($sformatf("vec[%0d]", i),
                   {req_ready, winc, wdata, grant_id, busy, word_cnt},
                   {tbl[i].ready, tbl[i].winc, tbl[i].wdata, tbl[i].gid, tbl[i].busy, tbl[i].wc});
      if (winc) written.push_back(wdata);
      tick();
    end
  endtask

  initial begin
    int got;
    int cnt;
    logic w;
    logic seen_af;
    logic found;

    // Single requester 0 streams 0x10..0x19: bursts of 4,4,2.
    add_vec(1, 4'b0001, 32'h10, 4'b0000, 0, 8'h00, 0, 0, 0);
    add_vec(1, 4'b0001, 32'h10, 4'b0001, 0, 8'h00, 0, 1, 0);
    add_vec(1, 4'b0001, 32'h11, 4'b0001, 1, 8'h10, 0, 1, 1);
    add_vec(1, 4'b0001, 32'h12, 4'b0001, 1, 8'h11, 0, 1, 2);
    add_vec(1, 4'b0001, 32'h13, 4'b0001, 1, 8'h12, 0, 1, 3);
    add_vec(1, 4'b0001, 32'h14, 4'b0000, 1, 8'h13, 0, 0, 4);
    add_vec(1, 4'b0001, 32'h14, 4'b0001, 0, 8'h13, 0, 1, 4);
    add_vec(1, 4'b0001, 32'h15, 4'b0001, 1, 8'h14, 0, 1, 5);
    add_vec(1, 4'b0001, 32'h16, 4'b0001, 1, 8'h15, 0, 1, 6);
    add_vec(1, 4'b0001, 32'h17, 4'b0001, 1, 8'h16, 0, 1, 7);
    add_vec(1, 4'b0001, 32'h18, 4'b0000, 1, 8'h17, 0, 0, 8);
    add_vec(1, 4'b0001, 32'h18, 4'b0001, 0, 8'h17, 0, 1, 8);
    add_vec(1, 4'b0001, 32'h19, 4'b0001, 1, 8'h18, 0, 1, 9);
    add_vec(1, 4'b0000, 32'h00, 4'b0001, 1, 8'h19, 0, 1, 10);
    add_vec(1, 4'b0000, 32'h00, 4'b0000, 0, 8'h19, 0, 0, 10);
    add_vec(0, 4'b0000, 32'h00, 4'b0000, 0, 8'h19, 0, 0, 10);
    add_vec(1, 4'b0000, 32'h00, 4'b0000, 0, 8'h00, 0, 0, 0);
    // Requester 2 releases after 2 words; next grant to 3, then a wrap to 0.
    add_vec(1, 4'b0100, 32'h0020_0000, 4'b0000, 0, 8'h00, 0, 0, 0);
    add_vec(1, 4'b0100, 32'h0020_0000, 4'b0100, 0, 8'h00, 2, 1, 0);
    add_vec(1, 4'b0100, 32'h0021_0000, 4'b0100, 1, 8'h20, 2, 1, 1);
    add_vec(1, 4'b1000, 32'h3300_0000, 4'b0100, 1, 8'h21, 2, 1, 2);
    add_vec(1, 4'b1000, 32'h3300_0000, 4'b0000, 0, 8'h21, 2, 0, 2);
    add_vec(1, 4'b1000, 32'h3300_0000, 4'b1000, 0, 8'h21, 3, 1, 2);
    add_vec(1, 4'b0000, 32'h0000_0000, 4'b1000, 1, 8'h33, 3, 1, 3);
    add_vec(1, 4'b0000, 32'h0000_0000, 4'b0000, 0, 8'h33, 3, 0, 3);
    add_vec(1, 4'b0100, 32'h0044_0000, 4'b0000, 0, 8'h33, 3, 0, 3);
    add_vec(1, 4'b0100, 32'h0044_0000, 4'b0100, 0, 8'h33, 2, 1, 3);
    add_vec(1, 4'b0100, 32'h0045_0000, 4'b0100, 1, 8'h44, 2, 1, 4);
    add_vec(1, 4'b0001, 32'h0000_0055, 4'b0100, 1, 8'h45, 2, 1, 5);
    add_vec(1, 4'b0001, 32'h0000_0055, 4'b0000, 0, 8'h45, 2, 0, 5);
    add_vec(1, 4'b0001, 32'h0000_0055, 4'b0001, 0, 8'h45, 0, 1, 5);
    add_vec(1, 4'b0000, 32'h0000_0000, 4'b0001, 1, 8'h55, 0, 1, 6);
    add_vec(1, 4'b0000, 32'h0000_0000, 4'b0000, 0, 8'h55, 0, 0, 6);
    // Reset mid-burst of requester 1; the next grant restarts from requester 0.
    add_vec(1, 4'b0010, 32'h0000_6000, 4'b0000, 0, 8'h55, 0, 0, 6);
    add_vec(1, 4'b0010, 32'h0000_6000, 4'b0010, 0, 8'h55, 1, 1, 6);
    add_vec(1, 4'b0010, 32'h0000_6100, 4'b0010, 1, 8'h60, 1, 1, 7);
    add_vec(0, 4'b0010, 32'h0000_6200, 4'b0000, 1, 8'h61, 1, 1, 8);
    add_vec(1, 4'b0011, 32'h0000_6270, 4'b0000, 0, 8'h00, 0, 0, 0);
    add_vec(1, 4'b0011, 32'h0000_6270, 4'b0001, 0, 8'h00, 0, 1, 0);
    add_vec(1, 4'b0000, 32'h0000_0000, 4'b0001, 1, 8'h70, 0, 1, 1);
    add_vec(1, 4'b0000, 32'h0000_0000, 4'b0000, 0, 8'h70, 0, 0, 1);

    exp_written = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19,
                    8'h20, 8'h21, 8'h33, 8'h44, 8'h45, 8'h55, 8'h60, 8'h61, 8'h70};

    do_reset();
    tick();
    do_reset();
    #1;
    check_output("rst_winc", winc, 0);
    check_output("rst_wdata", wdata, 0);
    check_output("rst_ready", req_ready, 0);
    check_output("rst_grant_id", grant_id, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_overflow", overflow_err, 0);
    check_output("rst_word_cnt", word_cnt, 0);

    apply_stimulus();
    check_output("fifo_len", written.size(), exp_written.size());
    for (int i = 0; i < written.size() && i < exp_written.size(); i++)
      check_output($sformatf("fifo_word[%0d]", i), written[i], exp_written[i]);

    // All four requesters valid: grants rotate 0,1,2,3,0 with 4 words each.
    do_reset();
    req_valid = 4'b1111;
    req_data  = 32'hA3A2_A1A0;
    got = 0;
    for (int c = 0; c < 200 && got < 20; c++) begin
      if (winc) begin
        check_output($sformatf("rr_word[%0d]", got), wdata, 32'hA0 + ((got / 4) % 4));
        got++;
      end
      tick();
    end
    if (got < 20) check_output("rr_timeout", got, 20);

    // Fill a 16-deep FIFO with the reader stopped, then drain 4 and resume.
    do_reset();
    req_valid = 4'b0010;
    req_data  = 32'h0000_C100;
    cnt       = 0;
    seen_af   = 1'b0;
    for (int c = 0; c < 80; c++) begin
      walmost_full = (cnt >= 15);
      wfull        = (cnt >= 16);
      #1;
      if (walmost_full && !seen_af) begin
        seen_af = 1'b1;
        check_output("ready_drop", req_ready, 0);
      end
      if (winc && wfull) check_output("write_into_full", 1, 0);
      w = winc;
      tick();
      cnt += int'(w);
    end
    walmost_full = (cnt >= 15);
    wfull        = (cnt >= 16);
    #1;
    check_output("almost_full_seen", seen_af, 1);
    check_output("fill_count", cnt, 16);
    check_output("fill_overflow", overflow_err, 0);
    check_output("fill_busy", busy, 1);
    check_output("fill_ready", req_ready, 0);
    check_output("fill_winc", winc, 0);
    cnt   = cnt - 4;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      walmost_full = (cnt >= 15);
      wfull        = (cnt >= 16);
      #1;
      if (winc) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check_output("resume_winc", found, 1);

    // Full asserted without almost-full while a word is in flight.
    do_reset();
    req_valid = 4'b0001;
    req_data  = 32'h0000_00F0;
    found     = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (winc) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (found) begin
      wfull = 1'b1;
      tick();
      check_output("overflow_set", overflow_err, 1);
      wfull     = 1'b0;
      req_valid = '0;
      repeat (5) tick();
      check_output("overflow_sticky", overflow_err, 1);
      do_reset();
      #1;
      check_output("overflow_clear", overflow_err, 0);
    end else begin
      check_output("overflow_winc_timeout", found, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
